// File: rtl/trivium_ctrl.sv
// trivium_ctrl
//   Sequencer for a Trivium keystream core. On start it reloads the core,
//   runs WARMUP discarded steps, then packs keystream bits LSB-first into
//   bytes and delivers exactly len bytes on a valid/ready port. When a byte
//   would complete while the output register is still held, the core is
//   stalled so no keystream bit is dropped or duplicated.
//
// Optional feature macro: TRIVIUM_CTRL_XOR_EN
//   When defined, adds a plaintext input port. Each completed keystream byte
//   is XORed with pt_data, and the core stalls until pt_valid is present.
//
// Ports
//   clk, rst         clock, asynchronous active-low reset
//   start, abort     begin a session (IDLE only) / cancel from any state
//   len              bytes to deliver, latched on accepted start
//   core_rst_n       active-low reset to the core (low for one LOAD cycle)
//   core_en          core step enable
//   ks_bit           keystream bit of the core's current state
//   out_data/valid   output byte and its valid, out_ready from the consumer
//   pt_data/valid    plaintext byte (XOR build only), pt_ready consumes it
//   busy             high whenever not IDLE
//   done             one-cycle pulse after the last byte is accepted
module trivium_ctrl #(
  parameter int WARMUP = 1152,
  parameter int LEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] len,
  output logic             core_rst_n,
  output logic             core_en,
  input  logic             ks_bit,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef TRIVIUM_CTRL_XOR_EN
  input  logic [7:0]       pt_data,
  input  logic             pt_valid,
  output logic             pt_ready,
`endif
  output logic             busy,
  output logic             done
);

  // Warm-up counter is at least 11 bits, wider only if WARMUP demands it.
  localparam int WC_W = ($clog2(WARMUP + 1) > 11) ? $clog2(WARMUP + 1) : 11;
  localparam logic [WC_W-1:0] WARM_LAST = WC_W'(WARMUP - 1);

  typedef enum logic [2:0] {IDLE, LOAD, WARM, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [WC_W-1:0]  warm_cnt;
  logic [2:0]       bitcnt;
  logic [6:0]       collect;
  logic [LEN_W-1:0] remain;

  logic handshake;
  logic out_full;
  logic byte_done;
  logic [7:0] ks_byte;

  assign handshake = out_valid && out_ready;
  // The 8th bit has nowhere to go while the previous byte is still held.
  assign out_full  = (bitcnt == 3'd7) && out_valid && !out_ready;
  assign byte_done = (state == RUN) && (bitcnt == 3'd7) && core_en;
  // collect holds bits 0..6 of the byte; the live ks_bit supplies bit 7.
  assign ks_byte   = {ks_bit, collect};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    core_en    = 1'b0;
    core_rst_n = 1'b1;
    busy       = (state != IDLE);
`ifdef TRIVIUM_CTRL_XOR_EN
    pt_ready   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start && (len != '0)) state_nxt = LOAD;
      end
      LOAD: begin
        core_rst_n = 1'b0;
        state_nxt  = WARM;
      end
      WARM: begin
        core_en = 1'b1;
        if (warm_cnt == WARM_LAST) state_nxt = RUN;
      end
      RUN: begin
`ifdef TRIVIUM_CTRL_XOR_EN
        core_en = !out_full && !((bitcnt == 3'd7) && !pt_valid);
`else
        core_en = !out_full;
`endif
        if (core_en && (bitcnt == 3'd7) && (remain == LEN_W'(1)))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (handshake) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
`ifdef TRIVIUM_CTRL_XOR_EN
    pt_ready = byte_done && !abort;
`endif
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm_cnt  <= '0;
      bitcnt    <= '0;
      collect   <= '0;
      remain    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      warm_cnt  <= '0;
      bitcnt    <= '0;
      collect   <= '0;
      remain    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) done   <= 1'b1;
            else           remain <= len;
          end
        end
        LOAD: begin
          warm_cnt <= '0;
          bitcnt   <= '0;
        end
        WARM: begin
          warm_cnt <= warm_cnt + 1'b1;
        end
        RUN: begin
          // A handshake empties the register unless a new byte lands now.
          if (handshake) out_valid <= 1'b0;
          if (core_en) begin
            bitcnt  <= bitcnt + 1'b1;
            collect <= {ks_bit, collect[6:1]};
            if (byte_done) begin
`ifdef TRIVIUM_CTRL_XOR_EN
              out_data <= ks_byte ^ pt_data;
`else
              out_data <= ks_byte;
`endif
              out_valid <= 1'b1;
              remain    <= remain - LEN_W'(1);
            end
          end
        end
        DRAIN: begin
          if (handshake) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/trivium_ctrl.md
# trivium_ctrl

Sequencer for the Trivium keystream core. On `start` it reloads the core, runs the warm-up rounds and collects keystream bits into bytes. It delivers exactly `len` bytes on a valid/ready output port and stalls the core under backpressure. It sits between the core and the byte-wide consumer, owning the core's reset and enable.

## Interface
- `WARMUP`, default 1152: number of discarded warm-up core steps.
- `LEN_W`, default 16: width of the byte-count input.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: begin a session. Sampled only in IDLE.
- `abort`, in, 1: cancel the session from any state.
- `len`, in, LEN_W: number of bytes to deliver. Latched on accepted `start`.
- `core_rst_n`, out, 1: drives the core's active-low reset.
- `core_en`, out, 1: core step enable. The core shifts once per cycle while it is high.
- `ks_bit`, in, 1: core keystream bit. It is combinationally valid for the core's current state.
- `out_data`, out, 8: keystream byte (or ciphertext byte, see Configuration).
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: consumer accepts the byte.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when the last byte is accepted.

## Operation
- The FSM has five states: IDLE, LOAD, WARM, RUN, DRAIN.
- IDLE:
  - A `start` with `len`≠0 latches `len` and moves to LOAD.
  - A `start` with `len`==0 pulses `done` the next cycle and stays in IDLE. The core is not touched.
- LOAD lasts one cycle:
  - `core_rst_n`=0 and `core_en`=0.
  - The warm-up counter is cleared, then the FSM moves to WARM.
- WARM:
  - `core_en`=1 and `ks_bit` is ignored.
  - The counter increments each cycle. After WARMUP cycles the FSM moves to RUN.
- RUN:
  - In each cycle with `core_en`=1, `ks_bit` is shifted into a collect register at bit index `bitcnt`. The first bit of a byte goes to bit 0 (LSB-first).
  - `bitcnt` runs 0..7 and wraps.
  - When `bitcnt`==7 is sampled, the completed byte is moved into the output register and `out_valid` is set.
  - The remaining-byte counter decrements when a byte is completed.
  - When the last byte is completed, the FSM moves to DRAIN.
- Backpressure rule: `core_en` = RUN & !(`bitcnt`==7 & `out_valid` & !`out_ready`).
  - Collection continues while the output register is held.
  - The core stalls only when an 8th bit would have nowhere to go.
  - No keystream bit is ever dropped or duplicated.
- Simultaneous accept and complete (`out_valid`&`out_ready` in the same cycle as the 8th bit): the new byte loads and `out_valid` stays 1.
- DRAIN: `core_en`=0. On the `out_valid`&`out_ready` handshake: `out_valid`→0, `done`=1 for one cycle, and the FSM returns to IDLE.
- `abort`: from any state, the next state is IDLE.
  - `out_valid`, `bitcnt` and the counters clear.
  - `done` is not pulsed.
  - `abort` has priority over `start` and over a handshake in the same cycle.
- `start` while `busy` is ignored.
- `len` changes after acceptance have no effect.

## Timing
- Reset values: state IDLE, `core_rst_n`=1, `core_en`=0, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, all counters 0.
- `start` sampled at edge 0:
  - LOAD during cycle 1.
  - WARM during cycles 2..WARMUP+1.
  - First RUN sample in cycle WARMUP+2.
  - First `out_valid` from cycle WARMUP+10.
- With `out_ready` held at 1, one byte is delivered every 8 cycles. The core never stalls.
- The last byte's handshake cycle is followed by `done` high in the next cycle, with `busy` low in that same cycle.
- Counters: the warm-up counter is 11 bits wide, minimum ceil(log2(WARMUP+1)). The byte counter is LEN_W bits wide and does not wrap; `len`=2^LEN_W−1 is legal.
- `out_data` stays stable while `out_valid`&!`out_ready`.

## Configuration
- `TRIVIUM_CTRL_XOR_EN` defined:
  - Adds input ports `pt_data` [7:0] and `pt_valid`, and output `pt_ready`.
  - A completed byte loads `out_data` = keystream byte ^ `pt_data`. The plaintext byte is consumed (`pt_ready`=1) in that cycle.
  - If `pt_valid`=0 when the 8th bit is due, `core_en` also deasserts (stall) until `pt_valid` is 1.
- Not defined: the ports are absent and `out_data` is the raw keystream byte.

## Test plan
- Reset with `WARMUP`=1152: all outputs are at their reset values. `start`, `len`=3, `out_ready`=1 → `core_rst_n` low exactly one cycle (cycle 1). First `out_valid` at cycle 1162. Three bytes spaced 8 cycles apart match the reference-model bytes LSB-first. `done` is one cycle after the third handshake.
- `len`=0 `start` → `done` pulse the next cycle, `core_rst_n` never low, `busy` stays 0.
- `len`=4, `out_ready` low for 20 cycles after the first `out_valid`:
  - `core_en` drops after 7 further bits.
  - `out_data` stays stable.
  - The byte stream equals the no-stall run.
- `abort` asserted in WARM cycle 500, then `start` `len`=1 → the full LOAD/WARM sequence restarts and the output byte equals keystream byte 0. No `done` is pulsed for the aborted session.
- `start` pulses while `busy` → no effect. `rst` low mid-RUN → immediate reset values, and `out_valid` drops asynchronously.
- With `TRIVIUM_CTRL_XOR_EN`: `pt_data`=0xFF on every byte → `out_data` = ~keystream byte. Withholding `pt_valid` for 10 cycles → the core stalls and no bit is lost.
